// File: rtl/asap_pkg.sv
// ---------------------------------------------------------------------------
// asap_pkg
//
// Shared definitions for the 8-bit computer's sequencing logic:
//   - opcode constants (upper nibble of the instruction register)
//   - control-word width and bit positions of every datapath strobe
//   - cu_decode(): the microcode ROM, expressed as a pure function of
//     (step, opcode, latched zero flag, latched carry flag)
//
// Keeping the microcode in a function lets the control unit evaluate it
// twice: once for the current step (the strobes on the ports) and, when
// early instruction end is compiled in, once for the following step.
// ---------------------------------------------------------------------------
package asap_pkg;

    // Control word layout
    localparam int CW_W = 16;

    typedef logic [CW_W-1:0] ctrl_word_t;

    localparam int CW_HLT = 15;  // halt clock/display
    localparam int CW_MI  = 14;  // memory address register in
    localparam int CW_RI  = 13;  // RAM in
    localparam int CW_RO  = 12;  // RAM out
    localparam int CW_IO  = 11;  // instruction register operand out
    localparam int CW_II  = 10;  // instruction register in
    localparam int CW_AI  = 9;   // A register in
    localparam int CW_AO  = 8;   // A register out
    localparam int CW_EO  = 7;   // ALU out
    localparam int CW_SU  = 6;   // ALU subtract
    localparam int CW_BI  = 5;   // B register in
    localparam int CW_OI  = 4;   // output register in
    localparam int CW_CE  = 3;   // program counter enable
    localparam int CW_CO  = 2;   // program counter out
    localparam int CW_J   = 1;   // program counter load
    localparam int CW_FI  = 0;   // flags register in

    // Opcodes; 1001..1101 are unassigned and decode as NOP.
    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Microcode. The fetch steps (T0, T1) ignore the opcode entirely, so
    // the instruction register may still be loading while they run.
    // Any step beyond T4 decodes to an empty word.
    function automatic ctrl_word_t cu_decode(
        input logic [2:0] step,
        input logic [3:0] opcode,
        input logic       zf_q,
        input logic       cf_q
    );
        ctrl_word_t cw;
        cw = '0;
        case (step)
            3'd0: begin
                cw[CW_CO] = 1'b1;
                cw[CW_MI] = 1'b1;
            end
            3'd1: begin
                cw[CW_RO] = 1'b1;
                cw[CW_II] = 1'b1;
                cw[CW_CE] = 1'b1;
            end
            3'd2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        cw[CW_IO] = 1'b1;
                        cw[CW_MI] = 1'b1;
                    end
                    OP_LDI: begin
                        cw[CW_IO] = 1'b1;
                        cw[CW_AI] = 1'b1;
                    end
                    OP_JMP: begin
                        cw[CW_IO] = 1'b1;
                        cw[CW_J]  = 1'b1;
                    end
                    OP_JC: begin
                        cw[CW_IO] = cf_q;
                        cw[CW_J]  = cf_q;
                    end
                    OP_JZ: begin
                        cw[CW_IO] = zf_q;
                        cw[CW_J]  = zf_q;
                    end
                    OP_OUT: begin
                        cw[CW_AO] = 1'b1;
                        cw[CW_OI] = 1'b1;
                    end
                    OP_HLT: begin
                        cw[CW_HLT] = 1'b1;
                    end
                    default: cw = '0;
                endcase
            end
            3'd3: begin
                case (opcode)
                    OP_LDA: begin
                        cw[CW_RO] = 1'b1;
                        cw[CW_AI] = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw[CW_RO] = 1'b1;
                        cw[CW_BI] = 1'b1;
                    end
                    OP_STA: begin
                        cw[CW_AO] = 1'b1;
                        cw[CW_RI] = 1'b1;
                    end
                    default: cw = '0;
                endcase
            end
            3'd4: begin
                case (opcode)
                    OP_ADD, OP_SUB: begin
                        // ALU result onto the bus into A; the flags register
                        // samples zf/cf on the same edge, so they describe the
                        // sum/difference of the pre-update A and B.
                        cw[CW_EO] = 1'b1;
                        cw[CW_AI] = 1'b1;
                        cw[CW_FI] = 1'b1;
                        cw[CW_SU] = (opcode == OP_SUB);
                    end
                    default: cw = '0;
                endcase
            end
            default: cw = '0;
        endcase
        return cw;
    endfunction

endpackage

// File: rtl/control_unit_step_counter.sv
// ---------------------------------------------------------------------------
// step_counter
//
// Microstep counter for a multi-step controller. Counts 0..STEPS-1 and wraps.
//
// Parameters:
//   STEPS      steps per instruction; the counter is 3 bits wide, so 2..8
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset, forces step to 0
//   early_end  return to 0 on this edge instead of advancing
//   freeze     hold the current step (takes priority over early_end/wrap)
//   step       current microstep
// ---------------------------------------------------------------------------
module step_counter #(
    parameter int STEPS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       early_end,
    input  logic       freeze,
    output logic [2:0] step
);

    localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            step <= 3'd0;
        end else if (freeze) begin
            step <= step;
        end else if (early_end || (step == LAST_STEP)) begin
            step <= 3'd0;
        end else begin
            step <= step + 3'd1;
        end
    end

endmodule

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//
// Microcoded sequencer for the 8-bit computer. Decodes (step, opcode,
// latched flags) into a 16-bit control word and fans it out onto the
// datapath strobes. Owns the microstep counter, the halt latch and the
// zero/carry flags register.
//
// Build option:
//   CU_EARLY_END_EN  when defined, an instruction ends as soon as its next
//                    execute step (T2 or later) would emit no strobes, so
//                    instructions take 3..5 cycles instead of STEPS.
//
// Parameters:
//   STEPS    microsteps per instruction (5..8)
// Ports:
//   clk      system clock, all state on the rising edge
//   rst      synchronous active-high reset
//   opcode   upper nibble of the instruction register (used from T2 on)
//   zf, cf   combinational ALU zero/carry flags
//   hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi
//            datapath control strobes (combinational, valid with step)
//   zf_q     latched zero flag
//   cf_q     latched carry flag
//   step     current microstep (debug view of the sequencer state)
//
// Strobes are a same-cycle decode of the registered state; the blocks they
// drive capture on the edge that ends the cycle. While rst is high every
// strobe is 0; while halted only hlt is 1.
// ---------------------------------------------------------------------------
module control_unit
    import asap_pkg::*;
#(
    parameter int STEPS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       zf,
    input  logic       cf,
    output logic       hlt,
    output logic       mi,
    output logic       ri,
    output logic       ro,
    output logic       io,
    output logic       ii,
    output logic       ai,
    output logic       ao,
    output logic       eo,
    output logic       su,
    output logic       bi,
    output logic       oi,
    output logic       ce,
    output logic       co,
    output logic       j,
    output logic       fi,
    output logic       zf_q,
    output logic       cf_q,
    output logic [2:0] step
);

    logic       halted;
    logic       early_end;
    logic       freeze;
    ctrl_word_t cw_now;
    ctrl_word_t cw_out;

    // Microcode for the current step.
    always_comb begin
        cw_now = cu_decode(step, opcode, zf_q, cf_q);
    end

    // Output gating: reset silences everything (including hlt); once halted
    // the word is pinned to "hlt only" regardless of step/opcode.
    always_comb begin
        cw_out = cw_now;
        if (rst) begin
            cw_out = '0;
        end else if (halted) begin
            cw_out         = '0;
            cw_out[CW_HLT] = 1'b1;
        end
    end

`ifdef CU_EARLY_END_EN
    // Look one step ahead; only execute steps may end an instruction early,
    // the fetch steps always run.
    logic [2:0] step_nxt;
    ctrl_word_t cw_next;

    always_comb begin
        step_nxt  = step + 3'd1;
        cw_next   = cu_decode(step_nxt, opcode, zf_q, cf_q);
        early_end = (step >= 3'd2) && (cw_next == '0);
    end
`else
    assign early_end = 1'b0;
`endif

    // The HLT step itself must not advance the counter, so the live hlt
    // strobe freezes it as well as the latched state.
    assign freeze = halted | cw_out[CW_HLT];

    step_counter #(
        .STEPS (STEPS)
    ) u_step_counter (
        .clk       (clk),
        .rst       (rst),
        .early_end (early_end),
        .freeze    (freeze),
        .step      (step)
    );

    // Halt latch and flags register. Reset has priority over a coincident
    // hlt (which is already gated to 0 while rst is high).
    always_ff @(posedge clk) begin
        if (rst) begin
            halted <= 1'b0;
            zf_q   <= 1'b0;
            cf_q   <= 1'b0;
        end else begin
            if (cw_out[CW_HLT]) begin
                halted <= 1'b1;
            end
            if (cw_out[CW_FI]) begin
                zf_q <= zf;
                cf_q <= cf;
            end
        end
    end

    // Fan the control word out onto the strobe ports.
    assign hlt = cw_out[CW_HLT];
    assign mi  = cw_out[CW_MI];
    assign ri  = cw_out[CW_RI];
    assign ro  = cw_out[CW_RO];
    assign io  = cw_out[CW_IO];
    assign ii  = cw_out[CW_II];
    assign ai  = cw_out[CW_AI];
    assign ao  = cw_out[CW_AO];
    assign eo  = cw_out[CW_EO];
    assign su  = cw_out[CW_SU];
    assign bi  = cw_out[CW_BI];
    assign oi  = cw_out[CW_OI];
    assign ce  = cw_out[CW_CE];
    assign co  = cw_out[CW_CO];
    assign j   = cw_out[CW_J];
    assign fi  = cw_out[CW_FI];

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
//
// Directed test of the control unit. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. Expected strobe
// words are built from the bench's own one-hot constants below.
// ---------------------------------------------------------------------------
module tb_control_unit;

    // Bench-side strobe encoding, independent of the design package.
    localparam logic [15:0] S_HLT = 16'h8000;
    localparam logic [15:0] S_MI  = 16'h4000;
    localparam logic [15:0] S_RI  = 16'h2000;
    localparam logic [15:0] S_RO  = 16'h1000;
    localparam logic [15:0] S_IO  = 16'h0800;
    localparam logic [15:0] S_II  = 16'h0400;
    localparam logic [15:0] S_AI  = 16'h0200;
    localparam logic [15:0] S_AO  = 16'h0100;
    localparam logic [15:0] S_EO  = 16'h0080;
    localparam logic [15:0] S_SU  = 16'h0040;
    localparam logic [15:0] S_BI  = 16'h0020;
    localparam logic [15:0] S_OI  = 16'h0010;
    localparam logic [15:0] S_CE  = 16'h0008;
    localparam logic [15:0] S_CO  = 16'h0004;
    localparam logic [15:0] S_J   = 16'h0002;
    localparam logic [15:0] S_FI  = 16'h0001;

    localparam logic [15:0] W_T0 = S_CO | S_MI;
    localparam logic [15:0] W_T1 = S_RO | S_II | S_CE;

    // clock / reset
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic       zf;
    logic       cf;

    logic hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi;
    logic       zf_q;
    logic       cf_q;
    logic [2:0] step;
    logic [15:0] cw_obs;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    control_unit #(
        .STEPS (5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .zf     (zf),
        .cf     (cf),
        .hlt    (hlt),
        .mi     (mi),
        .ri     (ri),
        .ro     (ro),
        .io     (io),
        .ii     (ii),
        .ai     (ai),
        .ao     (ao),
        .eo     (eo),
        .su     (su),
        .bi     (bi),
        .oi     (oi),
        .ce     (ce),
        .co     (co),
        .j      (j),
        .fi     (fi),
        .zf_q   (zf_q),
        .cf_q   (cf_q),
        .step   (step)
    );

    assign cw_obs = {hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi};

    // scoreboard check
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver: check step and strobes in the current cycle, then advance
    task automatic check_cycle(input string tag, input int exp_step, input logic [15:0] exp_cw);
        @(negedge clk);
        check({tag, "_step"}, 32'(step), 32'(exp_step));
        check({tag, "_cw"}, 32'(cw_obs), 32'(exp_cw));
        @(posedge clk);
        #1;
    endtask

    // Remaining empty steps of an instruction (only present at fixed length).
    task automatic tail(input string tag, input int from);
`ifndef CU_EARLY_END_EN
        for (int s = from; s < 5; s++) begin
            check_cycle(tag, s, 16'h0000);
        end
`else
        if (from < 0) check(tag, 32'(from), 32'd0);
`endif
    endtask

    task automatic fetch(input string tag);
        check_cycle({tag, "_t0"}, 0, W_T0);
        check_cycle({tag, "_t1"}, 1, W_T1);
    endtask

    initial begin
        rst    = 1'b1;
        opcode = 4'h0;
        zf     = 1'b0;
        cf     = 1'b0;

        // reset held: strobes forced low
        @(posedge clk);
        #1;
        check_cycle("rst_hold", 0, 16'h0000);
        rst = 1'b0;
        check("rst_zf_q", 32'(zf_q), 32'd0);
        check("rst_cf_q", 32'(cf_q), 32'd0);

        // ADD, zf=0 cf=1 sampled at end of T4
        opcode = 4'b0010; zf = 1'b0; cf = 1'b1;
        fetch("add");
        check_cycle("add_t2", 2, S_IO | S_MI);
        check_cycle("add_t3", 3, S_RO | S_BI);
        check_cycle("add_t4", 4, S_EO | S_AI | S_FI);
        check("add_cf_q", 32'(cf_q), 32'd1);
        check("add_zf_q", 32'(zf_q), 32'd0);

        // SUB, zf=1 cf=0
        opcode = 4'b0011; zf = 1'b1; cf = 1'b0;
        fetch("sub");
        check_cycle("sub_t2", 2, S_IO | S_MI);
        check_cycle("sub_t3", 3, S_RO | S_BI);
        check_cycle("sub_t4", 4, S_EO | S_AI | S_FI | S_SU);
        check("sub_zf_q", 32'(zf_q), 32'd1);
        check("sub_cf_q", 32'(cf_q), 32'd0);

        // JZ taken; live ALU flags differ but must not be latched
        opcode = 4'b1000; zf = 1'b0; cf = 1'b1;
        fetch("jz");
        check_cycle("jz_t2", 2, S_IO | S_J);
        tail("jz_tail", 3);
        check("jz_zf_keep", 32'(zf_q), 32'd1);
        check("jz_cf_keep", 32'(cf_q), 32'd0);

        // JC not taken
        opcode = 4'b0111;
        fetch("jc");
        check_cycle("jc_t2", 2, 16'h0000);
        tail("jc_tail", 3);

        // LDI, with a different opcode present during fetch
        opcode = 4'b1111;
        check_cycle("ldi_t0", 0, W_T0);
        check_cycle("ldi_t1", 1, W_T1);
        opcode = 4'b0101;
        check_cycle("ldi_t2", 2, S_IO | S_AI);
        tail("ldi_tail", 3);

        // LDA
        opcode = 4'b0001;
        fetch("lda");
        check_cycle("lda_t2", 2, S_IO | S_MI);
        check_cycle("lda_t3", 3, S_RO | S_AI);
        tail("lda_tail", 4);

        // STA
        opcode = 4'b0100;
        fetch("sta");
        check_cycle("sta_t2", 2, S_IO | S_MI);
        check_cycle("sta_t3", 3, S_AO | S_RI);
        tail("sta_tail", 4);

        // OUT
        opcode = 4'b1110;
        fetch("out");
        check_cycle("out_t2", 2, S_AO | S_OI);
        tail("out_tail", 3);

        // JMP
        opcode = 4'b0110;
        fetch("jmp");
        check_cycle("jmp_t2", 2, S_IO | S_J);
        tail("jmp_tail", 3);

        // undefined opcode behaves as NOP
        opcode = 4'b1010;
        fetch("undef");
        check_cycle("undef_t2", 2, 16'h0000);
        tail("undef_tail", 3);

        // HLT: frozen at step 2 with only hlt asserted
        opcode = 4'b1111;
        fetch("hlt");
        for (int k = 0; k < 11; k++) begin
            check_cycle("hlt_frozen", 2, S_HLT);
            opcode = 4'(k);
        end
        rst = 1'b1;
        check_cycle("hlt_rst", 2, 16'h0000);
        rst = 1'b0;
        opcode = 4'b0010; zf = 1'b1; cf = 1'b1;
        fetch("resume");

        // ADD to set both flags, then reset mid-ADD at T3
        check_cycle("add2_t2", 2, S_IO | S_MI);
        check_cycle("add2_t3", 3, S_RO | S_BI);
        check_cycle("add2_t4", 4, S_EO | S_AI | S_FI);
        check("add2_zf_q", 32'(zf_q), 32'd1);
        check("add2_cf_q", 32'(cf_q), 32'd1);
        fetch("add3");
        check_cycle("add3_t2", 2, S_IO | S_MI);
        rst = 1'b1;
        check_cycle("add3_t3_rst", 3, 16'h0000);
        check_cycle("rst_mid", 0, 16'h0000);
        check("rst_mid_zf_q", 32'(zf_q), 32'd0);
        check("rst_mid_cf_q", 32'(cf_q), 32'd0);
        rst = 1'b0;
        check_cycle("post_rst_t0", 0, W_T0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
